// File: rtl/grant_xfer_ctrl_if.sv
// Arbiter-side inputs and burst/monitor outputs of grant_xfer_ctrl.
// master is the transfer controller; slave is the arbiter/bus environment.
interface grant_xfer_ctrl_if #(
    parameter int BURST_LEN = 4,
    parameter int ERR_W     = 8
);
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    logic [3:0]        req;
    logic [3:0]        gnt;
    logic              op_error;
    logic              ack;
    logic              bus_valid;
    logic [1:0]        bus_sel;
    logic              bus_last;
    logic [BEAT_W-1:0] beat_cnt;
    logic [3:0]        done;
    logic [3:0]        starve;
    logic              multi_gnt_err;
    logic [ERR_W-1:0]  err_cnt;
    logic              abort;

    modport master (
        input  req, gnt, op_error, ack,
        output bus_valid, bus_sel, bus_last, beat_cnt, done, starve,
               multi_gnt_err, err_cnt, abort
    );

    modport slave (
        output req, gnt, op_error, ack,
        input  bus_valid, bus_sel, bus_last, beat_cnt, done, starve,
               multi_gnt_err, err_cnt, abort
    );
endinterface

// File: rtl/grant_xfer_ctrl.sv
// Turns a registered one-hot arbiter grant into a fixed-length bus burst, and monitors
// per-agent starvation and arbiter errors. Define GXC_TIMEOUT_EN to add the ack-idle abort.
module grant_xfer_ctrl #(
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int WAIT_W       = 4,
    parameter int ERR_W        = 8,
    parameter int TIMEOUT      = 16
) (
    input logic               clk,
    input logic               rst,
    grant_xfer_ctrl_if.master bus
);
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    if (BURST_LEN < 1 || (2 ** WAIT_W - 1) < STARVE_LIMIT || TIMEOUT < 1) begin : g_bad_param
        $error("grant_xfer_ctrl: illegal parameter set");
    end

    // state   | meaning
    // IDLE    | waiting for a one-hot grant
    // XFER    | burst owned by 'owner'; beat held until ack
    // DONE    | one-cycle done[owner] pulse, bus idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        owner;
    logic              valid_r;
    logic              last_r;
    logic [BEAT_W-1:0] beat_r;
    logic [3:0]        done_r;
    logic [3:0]        starve_r;
    logic              multi_r;
    logic [ERR_W-1:0]  err_r;
    logic [WAIT_W-1:0] wait_cnt [4];
    logic [WAIT_W-1:0] wait_nxt [4];

    logic              gnt_multi;
    logic              gnt_one_hot;
    logic [1:0]        gnt_idx;
    logic              start;
    logic              timeout_hit;

    assign gnt_multi   = |(bus.gnt & (bus.gnt - 4'd1));
    assign gnt_one_hot = (|bus.gnt) & ~gnt_multi;
    assign start       = (state == ST_IDLE) && gnt_one_hot;

    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.gnt[i]) gnt_idx = 2'(i);
        end
    end

`ifdef GXC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            abort_r;

    assign timeout_hit = (state == ST_XFER) && !bus.ack && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            abort_r  <= 1'b0;
        end else begin
            abort_r <= timeout_hit;
            if (state == ST_XFER && !bus.ack) idle_cnt <= idle_cnt + TO_W'(1);
            else                              idle_cnt <= '0;
        end
    end

    assign bus.abort = abort_r;
`else
    assign timeout_hit = 1'b0;
    assign bus.abort   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= 2'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            beat_r  <= '0;
            done_r  <= 4'd0;
        end else begin
            done_r <= 4'd0;
            case (state)
                ST_IDLE: begin
                    if (gnt_one_hot) begin
                        state   <= ST_XFER;
                        owner   <= gnt_idx;
                        valid_r <= 1'b1;
                        beat_r  <= '0;
                        last_r  <= (LAST_BEAT == '0);
                    end
                end
                ST_XFER: begin
                    if (bus.ack) begin
                        if (last_r) begin
                            state   <= ST_DONE;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            beat_r  <= '0;
                            done_r  <= 4'b0001 << owner;
                        end else begin
                            beat_r <= beat_r + BEAT_W'(1);
                            last_r <= ((beat_r + BEAT_W'(1)) == LAST_BEAT);
                        end
                    end else if (timeout_hit) begin
                        // abandoned burst: no done pulse for the owner
                        state   <= ST_IDLE;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        beat_r  <= '0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state   <= ST_IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    beat_r  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wait_nxt[i] = wait_cnt[i];
            if (!bus.req[i] || (start && gnt_idx == 2'(i))) wait_nxt[i] = '0;
            else if (wait_cnt[i] != WAIT_MAX)                wait_nxt[i] = wait_cnt[i] + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
            starve_r <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wait_cnt[i] <= wait_nxt[i];
                starve_r[i] <= (wait_nxt[i] >= STARVE_TH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_r <= 1'b0;
            err_r   <= '0;
        end else begin
            if (gnt_multi) multi_r <= 1'b1;
            if (bus.op_error && err_r != ERR_MAX) err_r <= err_r + ERR_W'(1);
        end
    end

    assign bus.bus_valid     = valid_r;
    assign bus.bus_sel       = owner;
    assign bus.bus_last      = last_r;
    assign bus.beat_cnt      = beat_r;
    assign bus.done          = done_r;
    assign bus.starve        = starve_r;
    assign bus.multi_gnt_err = multi_r;
    assign bus.err_cnt       = err_r;
endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// Bench for grant_xfer_ctrl: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_grant_xfer_ctrl;
    localparam int BURST_LEN    = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int WAIT_W       = 4;
    localparam int ERR_W        = 8;
    localparam int TIMEOUT      = 16;
    localparam int BEAT_W       = $clog2(BURST_LEN) + 1;
    localparam int WAIT_MAX     = 2 ** WAIT_W - 1;
    localparam int ERR_MAX      = 2 ** ERR_W - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    grant_xfer_ctrl_if #(.BURST_LEN(BURST_LEN), .ERR_W(ERR_W)) ifc ();

    grant_xfer_ctrl #(
        .BURST_LEN(BURST_LEN), .STARVE_LIMIT(STARVE_LIMIT), .WAIT_W(WAIT_W),
        .ERR_W(ERR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // reference model: burst in progress, beats accepted, done-cycle holdoff, monitors
    bit         m_active, m_cool, m_multi, m_abort;
    int         m_owner, m_acked, m_err, m_idle;
    int         m_wait [4];
    logic [3:0] m_done;

    task automatic model_reset();
        m_active = 0; m_cool = 0; m_multi = 0; m_abort = 0;
        m_owner = 0; m_acked = 0; m_err = 0; m_idle = 0; m_done = 4'd0;
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] g;
        bit         one_hot, start;
        int         idx;
        g       = ifc.gnt;
        one_hot = (g != 4'd0) && ((g & (g - 4'd1)) == 4'd0);
        idx     = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        start   = !m_active && !m_cool && one_hot;
        m_done  = 4'd0;
        m_abort = 0;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_active) begin
            if (ifc.ack) begin
                m_idle = 0;
                m_acked++;
                if (m_acked == BURST_LEN) begin
                    m_active = 0; m_acked = 0; m_cool = 1;
                    m_done = 4'b0001 << m_owner;
                end
            end else begin
`ifdef GXC_TIMEOUT_EN
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_active = 0; m_acked = 0; m_idle = 0; m_abort = 1;
                end
`endif
            end
        end else if (start) begin
            m_active = 1; m_owner = idx; m_acked = 0; m_idle = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (!ifc.req[i] || (start && idx == i)) m_wait[i] = 0;
            else if (m_wait[i] < WAIT_MAX)          m_wait[i]++;
        end
        if ((g & (g - 4'd1)) != 4'd0) m_multi = 1;
        if (ifc.op_error && m_err < ERR_MAX) m_err++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.req = 4'd0; ifc.gnt = 4'd0; ifc.op_error = 1'b0; ifc.ack = 1'b0;
        model_reset();
        #2;
        checks++; if (ifc.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.bus_valid); end
        checks++; if (ifc.bus_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", ifc.bus_sel); end
        checks++; if (ifc.bus_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", ifc.bus_last); end
        checks++; if (ifc.beat_cnt !== '0) begin errors++; $display("FAIL reset_beat: got %0d want 0", ifc.beat_cnt); end
        checks++; if (ifc.done !== 4'd0 || ifc.starve !== 4'd0) begin errors++; $display("FAIL reset_done_starve: got %b/%b want 0/0", ifc.done, ifc.starve); end
        checks++; if (ifc.multi_gnt_err !== 1'b0 || ifc.err_cnt !== '0 || ifc.abort !== 1'b0) begin
            errors++; $display("FAIL reset_err: got multi=%b cnt=%0d abort=%b want 0", ifc.multi_gnt_err, ifc.err_cnt, ifc.abort); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_burst();
        ifc.req = 4'b0010; ifc.gnt = 4'b0010; ifc.ack = 1'b1;
        tick();
        ifc.gnt = 4'd0; ifc.req = 4'd0;
        for (int c = 0; c < BURST_LEN; c++) begin
            checks++; if (ifc.bus_valid !== 1'b1 || ifc.bus_sel !== 2'd1) begin
                errors++; $display("FAIL single_valid_sel beat %0d: got %b/%0d want 1/1", c, ifc.bus_valid, ifc.bus_sel); end
            checks++; if (ifc.bus_last !== (c == BURST_LEN - 1) || ifc.beat_cnt !== BEAT_W'(c)) begin
                errors++; $display("FAIL single_last_beat %0d: got last=%b cnt=%0d", c, ifc.bus_last, ifc.beat_cnt); end
            tick();
        end
        checks++; if (ifc.done !== 4'b0010 || ifc.bus_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: got done=%b valid=%b want 0010/0", ifc.done, ifc.bus_valid); end
        tick();
        checks++; if (ifc.done !== 4'd0) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", ifc.done); end
    endtask

    task automatic test_ack_toggle();
        int n;
        ifc.gnt = 4'b0001; ifc.ack = 1'b0;
        tick();
        ifc.gnt = 4'd0;
        n = 0;
        while (ifc.bus_valid === 1'b1 && n < 20) begin
            checks++; if (ifc.beat_cnt !== BEAT_W'((n + 1) / 2) || ifc.bus_sel !== 2'd0) begin
                errors++; $display("FAIL toggle_beat cyc %0d: got cnt=%0d sel=%0d want %0d/0", n, ifc.beat_cnt, ifc.bus_sel, (n + 1) / 2); end
            ifc.ack = (n % 2 == 0);
            tick();
            n++;
        end
        checks++; if (n != 7) begin errors++; $display("FAIL toggle_len: got %0d cycles want 7", n); end
        checks++; if (ifc.done !== 4'b0001) begin errors++; $display("FAIL toggle_done: got %b want 0001", ifc.done); end
        ifc.ack = 1'b0;
        tick();
    endtask

    task automatic test_multi_gnt();
        ifc.gnt = 4'b1111; ifc.ack = 1'b0;
        tick();
        ifc.gnt = 4'd0;
        checks++; if (ifc.multi_gnt_err !== 1'b1 || ifc.bus_valid !== 1'b0) begin
            errors++; $display("FAIL multi_flag: got err=%b valid=%b want 1/0", ifc.multi_gnt_err, ifc.bus_valid); end
        tick();
        checks++; if (ifc.bus_valid !== 1'b0 || ifc.multi_gnt_err !== 1'b1) begin
            errors++; $display("FAIL multi_sticky: got valid=%b err=%b want 0/1", ifc.bus_valid, ifc.multi_gnt_err); end
        ifc.gnt = 4'b0001;
        tick();
        ifc.gnt = 4'b0100; ifc.ack = 1'b1;
        for (int c = 0; c < BURST_LEN; c++) begin
            checks++; if (ifc.bus_valid !== 1'b1 || ifc.bus_sel !== 2'd0) begin
                errors++; $display("FAIL locked_owner beat %0d: got valid=%b sel=%0d want 1/0", c, ifc.bus_valid, ifc.bus_sel); end
            tick();
        end
        ifc.gnt = 4'd0;
        checks++; if (ifc.done !== 4'b0001) begin errors++; $display("FAIL locked_done: got %b want 0001", ifc.done); end
        tick();
    endtask

    task automatic test_starve();
        ifc.req = 4'd0; ifc.gnt = 4'd0; ifc.ack = 1'b0;
        tick();
        ifc.req = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (ifc.starve[3] !== (k >= STARVE_LIMIT)) begin
                errors++; $display("FAIL starve_rise after %0d cycles: got %b want %b", k, ifc.starve[3], (k >= STARVE_LIMIT)); end
        end
        ifc.req = 4'd0;
        tick();
        checks++; if (ifc.starve !== 4'd0) begin errors++; $display("FAIL starve_clear: got %b want 0000", ifc.starve); end
    endtask

    task automatic test_err_saturate();
        ifc.op_error = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == ERR_MAX - 1 || k == ERR_MAX || k == 300) begin
                checks++; if (ifc.err_cnt !== ERR_W'(k > ERR_MAX ? ERR_MAX : k)) begin
                    errors++; $display("FAIL err_cnt after %0d: got %0d want %0d", k, ifc.err_cnt, (k > ERR_MAX ? ERR_MAX : k)); end
            end
        end
        ifc.op_error = 1'b0;
        tick();
        checks++; if (ifc.err_cnt !== ERR_W'(ERR_MAX) || ifc.bus_valid !== 1'b0) begin
            errors++; $display("FAIL err_hold: got cnt=%0d valid=%b want %0d/0", ifc.err_cnt, ifc.bus_valid, ERR_MAX); end
    endtask

    task automatic test_reset_mid_burst();
        ifc.gnt = 4'b0100; ifc.ack = 1'b1; ifc.req = 4'b0011;
        tick();
        ifc.gnt = 4'd0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ifc.bus_valid !== 1'b0 || ifc.bus_last !== 1'b0 || ifc.beat_cnt !== '0 || ifc.bus_sel !== 2'd0) begin
            errors++; $display("FAIL midrst_bus: got valid=%b last=%b cnt=%0d sel=%0d want 0", ifc.bus_valid, ifc.bus_last, ifc.beat_cnt, ifc.bus_sel); end
        checks++; if (ifc.done !== 4'd0 || ifc.starve !== 4'd0 || ifc.multi_gnt_err !== 1'b0 || ifc.err_cnt !== '0) begin
            errors++; $display("FAIL midrst_mon: got done=%b starve=%b multi=%b cnt=%0d want 0", ifc.done, ifc.starve, ifc.multi_gnt_err, ifc.err_cnt); end
        tick();
        rst = 1'b0; ifc.req = 4'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (ifc.done !== 4'd0 || ifc.bus_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_nodone cyc %0d: got done=%b valid=%b want 0", k, ifc.done, ifc.bus_valid); end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 4; i++) ifc.req[i] = ($urandom_range(99) < 85);
            ifc.gnt      = $urandom_range(1) ? (4'b0001 << $urandom_range(3)) : 4'd0;
            ifc.ack      = ($urandom_range(99) < 70);
            ifc.op_error = ($urandom_range(99) < 10);
            tick();
            checks++; if (ifc.bus_valid !== m_active) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, ifc.bus_valid, m_active); end
            if (m_active) begin
                checks++; if (ifc.bus_sel !== 2'(m_owner)) begin errors++; $display("FAIL rnd_sel cyc %0d: got %0d want %0d", cyc, ifc.bus_sel, m_owner); end
            end
            checks++; if (ifc.bus_last !== (m_active && m_acked == BURST_LEN - 1)) begin
                errors++; $display("FAIL rnd_last cyc %0d: got %b want %b", cyc, ifc.bus_last, (m_active && m_acked == BURST_LEN - 1)); end
            checks++; if (ifc.beat_cnt !== BEAT_W'(m_acked)) begin errors++; $display("FAIL rnd_beat cyc %0d: got %0d want %0d", cyc, ifc.beat_cnt, m_acked); end
            checks++; if (ifc.done !== m_done) begin errors++; $display("FAIL rnd_done cyc %0d: got %b want %b", cyc, ifc.done, m_done); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (ifc.starve[i] !== (m_wait[i] >= STARVE_LIMIT)) begin
                    errors++; $display("FAIL rnd_starve%0d cyc %0d: got %b want %b", i, cyc, ifc.starve[i], (m_wait[i] >= STARVE_LIMIT)); end
            end
            checks++; if (ifc.err_cnt !== ERR_W'(m_err) || ifc.multi_gnt_err !== m_multi) begin
                errors++; $display("FAIL rnd_err cyc %0d: got cnt=%0d multi=%b want %0d/%b", cyc, ifc.err_cnt, ifc.multi_gnt_err, m_err, m_multi); end
            checks++; if (ifc.abort !== m_abort) begin errors++; $display("FAIL rnd_abort cyc %0d: got %b want %b", cyc, ifc.abort, m_abort); end
        end
        ifc.gnt = 4'd0; ifc.ack = 1'b1; ifc.op_error = 1'b0; ifc.req = 4'd0;
        for (int k = 0; k < 8; k++) tick();
    endtask

`ifdef GXC_TIMEOUT_EN
    task automatic test_timeout();
        ifc.gnt = 4'b0010; ifc.ack = 1'b0;
        tick();
        ifc.gnt = 4'd0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            checks++; if (ifc.abort !== (k == TIMEOUT) || ifc.bus_valid !== (k != TIMEOUT)) begin
                errors++; $display("FAIL timeout idle %0d: got abort=%b valid=%b", k, ifc.abort, ifc.bus_valid); end
            checks++; if (ifc.done !== 4'd0) begin errors++; $display("FAIL timeout_done idle %0d: got %b want 0000", k, ifc.done); end
        end
        tick();
        checks++; if (ifc.abort !== 1'b0 || ifc.bus_valid !== 1'b0 || ifc.done !== 4'd0) begin
            errors++; $display("FAIL timeout_after: got abort=%b valid=%b done=%b want 0", ifc.abort, ifc.bus_valid, ifc.done); end
    endtask
`else
    task automatic test_timeout();
        ifc.gnt = 4'b1000; ifc.ack = 1'b0;
        tick();
        ifc.gnt = 4'd0;
        for (int k = 1; k <= 3 * TIMEOUT; k++) begin
            tick();
            checks++; if (ifc.bus_valid !== 1'b1 || ifc.abort !== 1'b0 || ifc.bus_sel !== 2'd3) begin
                errors++; $display("FAIL no_timeout idle %0d: got valid=%b abort=%b sel=%0d want 1/0/3", k, ifc.bus_valid, ifc.abort, ifc.bus_sel); end
        end
        ifc.ack = 1'b1;
        for (int k = 0; k < BURST_LEN; k++) tick();
        checks++; if (ifc.done !== 4'b1000) begin errors++; $display("FAIL no_timeout_done: got %b want 1000", ifc.done); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_ack_toggle();
        test_multi_gnt();
        test_starve();
        test_err_saturate();
        test_reset_mid_burst();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
